// File: rtl/bnn_pkg.sv
// Shared constants, FSM state type and score array type for the BNN frame loader.
// Also holds the column-wrap helper that maps a column sum back onto the 28-pixel row.
package bnn_pkg;

   localparam int IMG_ROWS      = 28;
   localparam int IMG_COLS      = 28;
   localparam int IMG_BYTES     = 98;
   localparam int DEF_N_CLASSES = 10;
   localparam int DEF_SCORE_W   = 7;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ARGMAX = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef logic [DEF_N_CLASSES-1:0][DEF_SCORE_W-1:0] score_arr_t;

   typedef struct packed {
      logic       row_inc;
      logic [4:0] col;
   } pix_step_t;

   // A column sum never reaches 2*IMG_COLS, so one conditional subtract replaces a modulo.
   function automatic pix_step_t col_wrap(input logic [5:0] col_sum);
      pix_step_t r;
      if (col_sum >= 6'(IMG_COLS)) begin
         r.row_inc = 1'b1;
         r.col     = 5'(col_sum - 6'(IMG_COLS));
      end else begin
         r.row_inc = 1'b0;
         r.col     = col_sum[4:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/bnn_frame_loader_if.sv
// Byte-stream input and result handshake between a host/consumer and the frame loader.
// The signal names carry the loader's own port directions.
interface bnn_frame_loader_if #(
   parameter int SCORE_W = 7
);
   logic               byte_valid_i;
   logic [7:0]         byte_data_i;
   logic               byte_ready_o;
   logic               res_valid_o;
   logic               res_ready_i;
   logic [3:0]         res_class_o;
   logic [SCORE_W-1:0] res_score_o;

   modport master (
      output byte_valid_i, byte_data_i, res_ready_i,
      input  byte_ready_o, res_valid_o, res_class_o, res_score_o
   );

   modport slave (
      input  byte_valid_i, byte_data_i, res_ready_i,
      output byte_ready_o, res_valid_o, res_class_o, res_score_o
   );
endinterface

// File: rtl/bnn_argmax_seq.sv
// Sequential argmax: one class per cycle after start, strict greater-than so ties keep the lowest index.
// done pulses for one cycle while best_idx/best_score hold the final result.
module bnn_argmax_seq
   import bnn_pkg::*;
#(
   parameter int N_CLASSES = 10,
   parameter int SCORE_W   = 7
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [N_CLASSES-1:0][SCORE_W-1:0] scores,
   output logic                              done,
   output logic [3:0]                        best_idx,
   output logic [SCORE_W-1:0]                best_score
);
   localparam int IDX_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

   logic [IDX_W-1:0]   cnt_r;
   logic               running_r;
   logic               done_r;
   logic [IDX_W-1:0]   best_idx_r;
   logic [SCORE_W-1:0] best_score_r;

   // Scan state: class 0 seeds the running best on start, the rest are compared one per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r        <= '0;
         running_r    <= 1'b0;
         done_r       <= 1'b0;
         best_idx_r   <= '0;
         best_score_r <= '0;
      end else begin
         done_r <= 1'b0;
         if (start) begin
            best_idx_r   <= '0;
            best_score_r <= scores[0];
            if (LAST_IDX == '0) begin
               running_r <= 1'b0;
               done_r    <= 1'b1;
            end else begin
               running_r <= 1'b1;
               cnt_r     <= IDX_W'(1);
            end
         end else if (running_r) begin
            if (scores[cnt_r] > best_score_r) begin
               best_idx_r   <= cnt_r;
               best_score_r <= scores[cnt_r];
            end
            if (cnt_r == LAST_IDX) begin
               running_r <= 1'b0;
               done_r    <= 1'b1;
            end else begin
               cnt_r <= cnt_r + IDX_W'(1);
            end
         end
      end
   end

   assign done       = done_r;
   assign best_idx   = 4'(best_idx_r);
   assign best_score = best_score_r;

endmodule

// File: rtl/bnn_frame_loader.sv
// Loads a 28x28 binary image byte by byte into the BNN input, lets the BNN settle,
// captures its class scores and reports the argmax class through a valid/ready handshake.
module bnn_frame_loader
   import bnn_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int N_CLASSES     = 10,
   parameter int SCORE_W       = 7
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   bnn_frame_loader_if.slave                     bus,
   output logic [0:0][IMG_ROWS-1:0][IMG_COLS-1:0] layer_o,
   input  logic [N_CLASSES-1:0][SCORE_W-1:0]     scores_i,
   output logic                                  trigger_o,
   output logic                                  busy_o
);
   localparam logic [6:0] LAST_BYTE   = 7'(IMG_BYTES - 1);
   localparam logic [7:0] LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

   state_t                                 state_r;
   logic [6:0]                             byte_cnt_r;
   logic [4:0]                             base_row_r;
   logic [4:0]                             base_col_r;
   logic [7:0]                             settle_cnt_r;
   logic [0:0][IMG_ROWS-1:0][IMG_COLS-1:0] layer_r;
   logic [N_CLASSES-1:0][SCORE_W-1:0]      score_buf_r;
   logic                                   start_r;
   logic                                   res_valid_r;
   logic [3:0]                             res_class_r;
   logic [SCORE_W-1:0]                     res_score_r;
   logic                                   trigger_r;
   logic                                   busy_r;
   logic                                   byte_ready_r;

   logic                                   accept_s;
   pix_step_t                              base_step_s;
   pix_step_t                              bit_step_s [8];
   logic [4:0]                             pix_row_s  [8];
   logic [4:0]                             pix_col_s  [8];
   logic                                   scan_done_s;
   logic [3:0]                             scan_idx_s;
   logic [SCORE_W-1:0]                     scan_score_s;

   assign accept_s    = bus.byte_valid_i & byte_ready_r;
   assign base_step_s = col_wrap({1'b0, base_col_r} + 6'd8);

   // base_row/base_col track pixel 8k, so each bit's position is one add and a wrap.
   always_comb begin
      for (int b = 0; b < 8; b++) begin
         bit_step_s[b] = col_wrap({1'b0, base_col_r} + 6'(b));
         pix_row_s[b]  = base_row_r + {4'd0, bit_step_s[b].row_inc};
         pix_col_s[b]  = bit_step_s[b].col;
      end
   end

   // Image store: only accepted bytes write, so unwritten pixels keep the previous frame.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         layer_r <= '0;
      end else if (accept_s) begin
         for (int b = 0; b < 8; b++) begin
            layer_r[0][pix_row_s[b]][pix_col_s[b]] <= bus.byte_data_i[b];
         end
      end
   end

   // Control FSM with all handshake and status outputs registered alongside the state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= ST_LOAD;
         byte_cnt_r   <= '0;
         base_row_r   <= '0;
         base_col_r   <= '0;
         settle_cnt_r <= '0;
         score_buf_r  <= '0;
         start_r      <= 1'b0;
         res_valid_r  <= 1'b0;
         res_class_r  <= '0;
         res_score_r  <= '0;
         trigger_r    <= 1'b0;
         busy_r       <= 1'b0;
         byte_ready_r <= 1'b1;
      end else begin
         start_r <= 1'b0;
         case (state_r)
            ST_LOAD: begin
               if (accept_s) begin
                  if (byte_cnt_r == LAST_BYTE) begin
                     byte_cnt_r   <= '0;
                     base_row_r   <= '0;
                     base_col_r   <= '0;
                     settle_cnt_r <= '0;
                     state_r      <= ST_SETTLE;
                     byte_ready_r <= 1'b0;
                     trigger_r    <= 1'b1;
                     busy_r       <= 1'b1;
                  end else begin
                     byte_cnt_r <= byte_cnt_r + 7'd1;
                     base_row_r <= base_row_r + {4'd0, base_step_s.row_inc};
                     base_col_r <= base_step_s.col;
                  end
               end
            end
            ST_SETTLE: begin
               if (settle_cnt_r == LAST_SETTLE) begin
                  score_buf_r <= scores_i;
                  start_r     <= 1'b1;
                  trigger_r   <= 1'b0;
                  state_r     <= ST_ARGMAX;
               end else begin
                  settle_cnt_r <= settle_cnt_r + 8'd1;
               end
            end
            ST_ARGMAX: begin
               if (scan_done_s) begin
                  res_valid_r <= 1'b1;
                  res_class_r <= scan_idx_s;
                  res_score_r <= scan_score_s;
                  state_r     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.res_ready_i) begin
                  res_valid_r  <= 1'b0;
                  busy_r       <= 1'b0;
                  byte_ready_r <= 1'b1;
                  state_r      <= ST_LOAD;
               end
            end
            default: begin
               state_r      <= ST_LOAD;
               res_valid_r  <= 1'b0;
               trigger_r    <= 1'b0;
               busy_r       <= 1'b0;
               byte_ready_r <= 1'b1;
            end
         endcase
      end
   end

   bnn_argmax_seq #(
      .N_CLASSES (N_CLASSES),
      .SCORE_W   (SCORE_W)
   ) u_argmax (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .start      (start_r),
      .scores     (score_buf_r),
      .done       (scan_done_s),
      .best_idx   (scan_idx_s),
      .best_score (scan_score_s)
   );

   assign layer_o          = layer_r;
   assign trigger_o        = trigger_r;
   assign busy_o           = busy_r;
   assign bus.byte_ready_o = byte_ready_r;
   assign bus.res_valid_o  = res_valid_r;
   assign bus.res_class_o  = res_class_r;
   assign bus.res_score_o  = res_score_r;

endmodule

// File: tb/tb_bnn_frame_loader.sv
// Directed bench for bnn_frame_loader: frame loading, settle/argmax timing, handshake and resets.
module tb_bnn_frame_loader;
   import bnn_pkg::*;

   logic                                   clk;
   logic                                   rst_ni;
   logic [0:0][IMG_ROWS-1:0][IMG_COLS-1:0] layer_o;
   score_arr_t                             scores_i;
   logic                                   trigger_o;
   logic                                   busy_o;

   bnn_frame_loader_if #(.SCORE_W(DEF_SCORE_W)) bus ();

   bnn_frame_loader #(
      .SETTLE_CYCLES (4),
      .N_CLASSES     (DEF_N_CLASSES),
      .SCORE_W       (DEF_SCORE_W)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .bus       (bus),
      .layer_o   (layer_o),
      .scores_i  (scores_i),
      .trigger_o (trigger_o),
      .busy_o    (busy_o)
   );

   int                                     n_checks = 0;
   int                                     n_fail   = 0;
   logic [7:0]                             frame_q [IMG_BYTES];
   logic [0:0][IMG_ROWS-1:0][IMG_COLS-1:0] exp_layer;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic build_expected(input int n_bytes);
      for (int p = 0; p < n_bytes * 8; p++) begin
         exp_layer[0][p / 28][p % 28] = frame_q[p / 8][p % 8];
      end
   endtask

   // Sends frame_q[0..n_bytes-1]; returns one step after the edge that accepted the last byte.
   task automatic send_frame(input int n_bytes, input bit gaps);
      int  k     = 0;
      int  guard = 0;
      logic rdy;
      while (k < n_bytes && guard < 2000) begin
         bus.byte_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.byte_data_i  = bus.byte_valid_i ? frame_q[k] : ~frame_q[k];
         @(negedge clk);
         rdy = bus.byte_ready_o;
         @(posedge clk);
         if (bus.byte_valid_i && rdy) k++;
         #1;
         guard++;
      end
      n_checks++;
      if (k != n_bytes) begin
         n_fail++;
         $display("FAIL send_frame: accepted %0d bytes, required %0d", k, n_bytes);
      end
   endtask

   // Counts edges from the last-byte edge to res_valid_o, plus trigger cycles and stray ready.
   task automatic wait_result(output int lat, output int trig_cnt, output bit ready_leak);
      lat        = -1;
      trig_cnt   = 0;
      ready_leak = 1'b0;
      for (int i = 0; i < 40 && lat < 0; i++) begin
         if (trigger_o) trig_cnt++;
         if (bus.byte_ready_o) ready_leak = 1'b1;
         if (bus.res_valid_o) begin
            lat = i;
         end else begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset;
      rst_ni           = 1'b0;
      bus.byte_valid_i = 1'b0;
      bus.byte_data_i  = 8'h00;
      bus.res_ready_i  = 1'b0;
      scores_i         = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.byte_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.byte_ready_o); end
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_checks++;
      if (trigger_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_trig_valid: got %b/%b want 0/0", trigger_o, bus.res_valid_o);
      end
      n_checks++;
      if (bus.res_class_o !== 4'd0 || bus.res_score_o !== 7'd0) begin
         n_fail++; $display("FAIL reset_result: got %0d/%0d want 0/0", bus.res_class_o, bus.res_score_o);
      end
      n_checks++;
      if (layer_o !== '0) begin n_fail++; $display("FAIL reset_layer: got nonzero image want all zero"); end
   endtask

   task automatic test_ff_frame;
      int lat, trig_cnt;
      bit leak;
      for (int k = 0; k < IMG_BYTES; k++) frame_q[k] = 8'hFF;
      scores_i    = '0;
      scores_i[0] = 7'd3;
      scores_i[1] = 7'd9;
      scores_i[2] = 7'd9;
      scores_i[3] = 7'd1;
      send_frame(IMG_BYTES, 1'b0);
      // byte_valid_i stays high through settle/scan: nothing must be accepted.
      wait_result(lat, trig_cnt, leak);
      bus.byte_valid_i = 1'b0;
      n_checks++;
      if (leak !== 1'b0) begin n_fail++; $display("FAIL ff_ready_low: byte_ready_o seen 1 after byte 97, want 0"); end
      n_checks++;
      if (trig_cnt != 4) begin n_fail++; $display("FAIL ff_trigger_len: got %0d cycles want 4", trig_cnt); end
      n_checks++;
      if (lat != 15) begin n_fail++; $display("FAIL ff_latency: got %0d want 15", lat); end
      n_checks++;
      if (layer_o !== {IMG_ROWS*IMG_COLS{1'b1}}) begin n_fail++; $display("FAIL ff_layer: image not all ones"); end
      n_checks++;
      if (bus.res_class_o !== 4'd1 || bus.res_score_o !== 7'd9) begin
         n_fail++; $display("FAIL ff_argmax_tie: got class %0d score %0d want 1/9", bus.res_class_o, bus.res_score_o);
      end
      n_checks++;
      if (busy_o !== 1'b1) begin n_fail++; $display("FAIL ff_busy: got %b want 1", busy_o); end
   endtask

   task automatic test_hold_done;
      bit bad_val = 1'b0;
      bit bad_res = 1'b0;
      bit bad_rdy = 1'b0;
      bus.res_ready_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.res_valid_o !== 1'b1) bad_val = 1'b1;
         if (bus.res_class_o !== 4'd1 || bus.res_score_o !== 7'd9) bad_res = 1'b1;
         if (bus.byte_ready_o !== 1'b0) bad_rdy = 1'b1;
      end
      n_checks++;
      if (bad_val) begin n_fail++; $display("FAIL hold_valid: res_valid_o dropped without handshake, want held 1"); end
      n_checks++;
      if (bad_res) begin n_fail++; $display("FAIL hold_result: result changed, want 1/9 stable"); end
      n_checks++;
      if (bad_rdy) begin n_fail++; $display("FAIL hold_ready: byte_ready_o went 1 in DONE, want 0"); end
      bus.res_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready_i = 1'b0;
      n_checks++;
      if (bus.res_valid_o !== 1'b0 || bus.byte_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release: valid/ready/busy got %b/%b/%b want 0/1/0",
                  bus.res_valid_o, bus.byte_ready_o, busy_o);
      end
   endtask

   task automatic test_reset_mid_frame;
      int lat, trig_cnt;
      bit leak;
      for (int k = 0; k < IMG_BYTES; k++) frame_q[k] = 8'hAA;
      send_frame(50, 1'b0);
      bus.byte_valid_i = 1'b0;
      #2 rst_ni = 1'b0;
      #3;
      n_checks++;
      if (layer_o !== '0 || bus.res_class_o !== 4'd0) begin
         n_fail++; $display("FAIL midframe_reset_clear: image/class not cleared, class=%0d", bus.res_class_o);
      end
      #4 rst_ni = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < IMG_BYTES; k++) frame_q[k] = 8'h01;
      exp_layer = '0;
      build_expected(IMG_BYTES);
      for (int c = 0; c < DEF_N_CLASSES; c++) scores_i[c] = 7'h7F;
      send_frame(IMG_BYTES, 1'b0);
      bus.byte_valid_i = 1'b0;
      wait_result(lat, trig_cnt, leak);
      n_checks++;
      if (layer_o !== exp_layer) begin n_fail++; $display("FAIL midframe_layer: image differs from p%%8==0 pattern"); end
      n_checks++;
      if (lat != 15) begin n_fail++; $display("FAIL midframe_latency: got %0d want 15", lat); end
      n_checks++;
      if (bus.res_class_o !== 4'd0 || bus.res_score_o !== 7'd127) begin
         n_fail++; $display("FAIL allmax_argmax: got class %0d score %0d want 0/127", bus.res_class_o, bus.res_score_o);
      end
      bus.res_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready_i = 1'b0;
   endtask

   task automatic test_random_gaps;
      int lat, trig_cnt;
      bit leak;
      for (int k = 0; k < IMG_BYTES; k++) frame_q[k] = 8'($urandom);
      build_expected(IMG_BYTES);
      scores_i    = '0;
      scores_i[2] = 7'h40;
      scores_i[5] = 7'd119;
      scores_i[9] = 7'd120;
      // res_ready_i held high all along: only the DONE handshake may use it.
      bus.res_ready_i = 1'b1;
      send_frame(IMG_BYTES, 1'b1);
      bus.byte_valid_i = 1'b0;
      wait_result(lat, trig_cnt, leak);
      n_checks++;
      if (layer_o !== exp_layer) begin n_fail++; $display("FAIL gaps_layer: image differs from p=8k+b mapping"); end
      n_checks++;
      if (lat != 15) begin n_fail++; $display("FAIL gaps_latency: got %0d want 15", lat); end
      n_checks++;
      if (bus.res_class_o !== 4'd9 || bus.res_score_o !== 7'd120) begin
         n_fail++; $display("FAIL gaps_argmax: got class %0d score %0d want 9/120", bus.res_class_o, bus.res_score_o);
      end
      @(posedge clk);
      #1;
      bus.res_ready_i = 1'b0;
      n_checks++;
      if (bus.res_valid_o !== 1'b0 || bus.byte_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL gaps_handshake: valid/ready got %b/%b want 0/1", bus.res_valid_o, bus.byte_ready_o);
      end
   endtask

   task automatic test_reset_mid_scan;
      for (int k = 0; k < IMG_BYTES; k++) frame_q[k] = 8'h5A;
      send_frame(IMG_BYTES, 1'b0);
      bus.byte_valid_i = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_ni = 1'b0;
      #2;
      n_checks++;
      if (bus.res_class_o !== 4'd0 || bus.res_score_o !== 7'd0 || bus.res_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midscan_result: class/score/valid got %0d/%0d/%b want 0/0/0",
                  bus.res_class_o, bus.res_score_o, bus.res_valid_o);
      end
      n_checks++;
      if (busy_o !== 1'b0 || trigger_o !== 1'b0 || layer_o !== '0) begin
         n_fail++; $display("FAIL midscan_state: busy/trigger got %b/%b or image not cleared", busy_o, trigger_o);
      end
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.byte_ready_o !== 1'b1) begin n_fail++; $display("FAIL midscan_ready: got %b want 1", bus.byte_ready_o); end
   endtask

   initial begin
      test_reset();
      test_ff_frame();
      test_hold_done();
      test_reset_mid_frame();
      test_random_gaps();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bnn_frame_loader.md
BNN_FRAME_LOADER -- requirements
Module: bnn_frame_loader

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles the combinational BNN is given before its scores are sampled; legal range 1..255.
REQ-002 Parameter N_CLASSES, default 10: number of class scores.
REQ-003 Parameter SCORE_W, default 7: width of each unsigned class score.
REQ-004 clk_i  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1: reset, asynchronous and active-low.
REQ-006 byte_valid_i  input  1: host image byte available.
REQ-007 byte_data_i  input  8: image byte; bit b of byte k is pixel 8k+b.
REQ-008 byte_ready_o  output  1: loader accepts a byte this cycle.
REQ-009 layer_o  output  [0:0][27:0][27:0]: packed image driven to the BNN layer_i.
REQ-010 scores_i  input  [N_CLASSES-1:0][SCORE_W-1:0]: BNN layer_o.
REQ-011 trigger_o  output  1: capture trigger; high exactly during SETTLE.
REQ-012 res_valid_o  output  1: result available.
REQ-013 res_ready_i  input  1: consumer accepts result.
REQ-014 res_class_o  output  4: argmax class index.
REQ-015 res_score_o  output  SCORE_W: score of the winning class.
REQ-016 busy_o  output  1: high in every state except LOAD.

Function
REQ-017 States: LOAD, SETTLE, ARGMAX, DONE; reset state LOAD.
REQ-018 LOAD: byte_ready_o=1; byte accepted on byte_valid_i & byte_ready_o; byte counter 0..97 increments per accepted byte.
REQ-019 Pixel p=8k+b is written to layer_o[0][p/28][p%28]; bits not yet written hold their previous frame value.
REQ-020 Accepting byte 97 transitions to SETTLE next cycle and clears the byte counter; no byte is accepted outside LOAD (byte_ready_o=0).
REQ-021 layer_o is stable (no writes) in SETTLE, ARGMAX and DONE.
REQ-022 SETTLE lasts exactly SETTLE_CYCLES cycles; on the last SETTLE cycle scores_i is registered into a local score buffer; transition to ARGMAX.
REQ-023 ARGMAX scans buffer index 0..N_CLASSES-1, one class per cycle (N_CLASSES cycles); a class replaces the running best only if strictly greater, so ties resolve to the lowest index.
REQ-024 After the scan, DONE: res_valid_o=1 with res_class_o/res_score_o stable until handshake.
REQ-025 res_valid_o & res_ready_i in DONE -> LOAD next cycle; res_valid_o deasserts the same edge.
REQ-026 Latency: from the edge accepting byte 97 to res_valid_o high = SETTLE_CYCLES + N_CLASSES + 1 cycles.
REQ-027 res_ready_i asserted outside DONE has no effect; res_valid_o never drops without a handshake.
REQ-028 Score comparison is unsigned over SCORE_W bits; res_class_o zero-extended.

Reset
REQ-029 rst_ni low, at any time including mid-frame or mid-scan: state LOAD, byte counter 0, layer_o all 0, score buffer 0, res_class_o 0, res_score_o 0, res_valid_o 0, trigger_o 0, busy_o 0, byte_ready_o 1 after release.
REQ-030 First byte after reset release is byte 0 of a new frame; partial frames are discarded.

Structure
REQ-031 Shared package bnn_pkg holds IMG_ROWS=28, IMG_COLS=28, IMG_BYTES=98, state enum type, and the score array typedef.
REQ-032 One sub-module, bnn_argmax_seq: sequential scan with start/done, inputs score buffer, outputs index and score.
REQ-033 Pixel row/column computed from the byte counter and bit position with constants, without run-time division.

Verification
REQ-034 Stream 98 bytes of 0xFF with byte_valid_i held high -> layer_o all ones; byte_ready_o low from the cycle after byte 97; trigger_o high for exactly 4 cycles.
REQ-035 scores_i = {3,9,9,1,0,0,0,0,0,0} (class 0..9) -> res_class_o=1, res_score_o=9, res_valid_o at cycle 15 after byte 97.
REQ-036 Hold res_ready_i=0 for 20 cycles in DONE -> outputs stable, byte_ready_o=0; then res_ready_i=1 -> LOAD next cycle.
REQ-037 Pulse rst_ni low after 50 bytes, then send a full frame of 0x01 -> only pixels with p%8==0 are 1; no stale bits from the aborted frame.
REQ-038 Random byte_valid_i gaps (50% duty) with random frame data -> layer_o matches reference bit mapping p=8k+b; bytes accepted only while byte_ready_o=1.
REQ-039 All scores = 0x7F -> res_class_o=0, res_score_o=127.
